// File: rtl/imem_arbiter_if.sv
// Request/response and memory-port signals shared by the fetch unit, debug bridge
// and instruction memory around imem_arbiter.
interface imem_arbiter_if #(
  parameter int unsigned DEPTH_WORDS = 256
) ();
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic             fetch_valid;
  logic [31:0]      fetch_addr;
  logic             fetch_ready;
  logic             fetch_rvalid;
  logic [31:0]      fetch_rdata;
  logic             fetch_err;

  logic             dbg_valid;
  logic             dbg_we;
  logic [31:0]      dbg_addr;
  logic [31:0]      dbg_wdata;
  logic             dbg_ready;
  logic             dbg_rvalid;
  logic [31:0]      dbg_rdata;
  logic             dbg_err;

  logic             mem_en;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  // Arbiter side
  modport slave (
    input  fetch_valid, fetch_addr,
    output fetch_ready, fetch_rvalid, fetch_rdata, fetch_err,
    input  dbg_valid, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ready, dbg_rvalid, dbg_rdata, dbg_err,
    output mem_en, mem_we, mem_idx, mem_wdata,
    input  mem_rdata
  );

  // Requester / memory side
  modport master (
    output fetch_valid, fetch_addr,
    input  fetch_ready, fetch_rvalid, fetch_rdata, fetch_err,
    output dbg_valid, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ready, dbg_rvalid, dbg_rdata, dbg_err,
    input  mem_en, mem_we, mem_idx, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between fetch and debug,
// with range/alignment rejection and one-cycle response routing.
module imem_arbiter #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  localparam logic       LG_FETCH  = 1'b0;
  localparam logic       LG_DBG    = 1'b1;
  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_FETCH = 2'd1;
  localparam logic [1:0] SRC_DBG   = 2'd2;

  logic        last_grant;
  logic [1:0]  resp_src;
  logic        resp_err;
  logic        resp_wr;

  logic        gnt_f;
  logic        gnt_d;
  logic        gnt;
  logic [31:0] sel_addr;
  logic        sel_legal;
  logic        sel_we;

  // Grants are masked by rst so every output reads 0 while reset is held.
  always_comb begin
    gnt_f     = !rst && bus.fetch_valid && (!bus.dbg_valid || last_grant == LG_DBG);
    gnt_d     = !rst && bus.dbg_valid && (!bus.fetch_valid || last_grant == LG_FETCH);
    gnt       = gnt_f || gnt_d;
    sel_addr  = gnt_d ? bus.dbg_addr : bus.fetch_addr;
    sel_legal = (sel_addr[31:IDX_W+2] == '0) && (sel_addr[1:0] == 2'b00);
    sel_we    = gnt_d && bus.dbg_we;
  end

  always_comb begin
    bus.fetch_ready = gnt_f;
    bus.dbg_ready   = gnt_d;
    bus.mem_en      = gnt && sel_legal;
    bus.mem_we      = sel_we && sel_legal;
    bus.mem_idx     = (gnt && sel_legal) ? sel_addr[IDX_W+1:2] : '0;
    bus.mem_wdata   = (sel_we && sel_legal) ? bus.dbg_wdata : '0;
  end

  always_comb begin
    bus.fetch_rvalid = (resp_src == SRC_FETCH);
    bus.fetch_err    = (resp_src == SRC_FETCH) && resp_err;
    bus.fetch_rdata  = ((resp_src == SRC_FETCH) && !resp_err) ? bus.mem_rdata : '0;
    bus.dbg_rvalid   = (resp_src == SRC_DBG);
    bus.dbg_err      = (resp_src == SRC_DBG) && resp_err;
    bus.dbg_rdata    = ((resp_src == SRC_DBG) && !resp_err && !resp_wr) ? bus.mem_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= LG_DBG;
      resp_src   <= SRC_NONE;
      resp_err   <= 1'b0;
      resp_wr    <= 1'b0;
    end else begin
      if (gnt) begin
        last_grant <= gnt_d ? LG_DBG : LG_FETCH;
      end
      resp_src <= gnt_d ? SRC_DBG : (gnt_f ? SRC_FETCH : SRC_NONE);
      resp_err <= gnt && !sel_legal;
      resp_wr  <= sel_we;
    end
  end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single instruction-memory port between the fetch unit and the debug/loader port. Grants at most one request per cycle using round-robin, drives the memory's address, enable and write controls, and returns the one-cycle-latency read data to the requester that issued the access. Out-of-range and misaligned accesses are rejected without touching memory. The block sits between the fetch stage, the debug bridge and a write-capable instruction memory of 1 KiB (256 words).

## Interface
- DEPTH_WORDS, 256, memory depth in 32-bit words (power of two); index width IDX_W = log2(DEPTH_WORDS).
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fetch_valid  in  1  fetch read request.
- fetch_addr  in  32  fetch byte address.
- fetch_ready  out  1  fetch request granted this cycle.
- fetch_rvalid  out  1  fetch response valid.
- fetch_rdata  out  32  fetch read data.
- fetch_err  out  1  fetch response is an error.
- dbg_valid  in  1  debug request.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  32  debug byte address.
- dbg_wdata  in  32  debug write data.
- dbg_ready  out  1  debug request granted this cycle.
- dbg_rvalid  out  1  debug response valid (reads and write acks).
- dbg_rdata  out  32  debug read data (0 for writes and errors).
- dbg_err  out  1  debug response is an error.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_idx  out  IDX_W  word index.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data, registered in memory, valid the cycle after mem_en.

## Operation
- Legal access: addr < 4*DEPTH_WORDS and addr[1:0] == 0; mem_idx = addr[IDX_W+1:2].
- Illegal access is granted normally but mem_en stays 0. Its response in the next cycle has err=1 and rdata=0.
- Arbitration is combinational from the valids and the last_grant register:
  - only one requester valid: that requester is granted;
  - both valid: grant the requester not in last_grant;
  - last_grant updates on every grant;
  - reset value of last_grant is DBG, so fetch wins the first tie.
- ready is asserted only to the granted requester and only when its valid is high. A request transfers when valid and ready are both high.
- A requester holds valid and its address/data stable until ready. Deasserting valid without a grant is permitted.
- Write (dbg_we=1, legal): mem_en=1, mem_we=1. The next cycle gives dbg_rvalid=1, dbg_err=0, dbg_rdata=0 as the ack.
- Fetch is read-only. A fetch never drives mem_we.
- Response tracking uses registers resp_src (NONE/FETCH/DBG), resp_err and resp_wr, loaded on every grant and cleared to NONE when there is no grant.
- Response outputs are combinational from those registers:
  - rdata = mem_rdata for a legal read;
  - rdata = 0 otherwise.
- Responses have no backpressure. Requesters must accept rvalid in the cycle it is asserted.
- mem_* are combinational from the granted request. When there is no grant: mem_en=0, mem_we=0, mem_idx=0, mem_wdata=0.

## Timing
- Cycle N: valid and ready high, mem_* driven. Cycle N+1: rvalid high with rdata/err. Read latency is 1 cycle.
- Back-to-back: a new grant is allowed every cycle. The cycle-N+1 grant's response appears in N+2. Throughput is 1 access per cycle.
- Alternating service: with both valid continuously, grants go F, D, F, D, ...
- Reset (async): resp_src=NONE, last_grant=DBG. Every output reads 0 while rst is high: ready, rvalid, rdata, err, mem_en, mem_we, mem_idx, mem_wdata.
- Reset asserted mid-access: the pending response is dropped. No rvalid appears in the first cycle after rst deasserts.
- Write then read of the same word in consecutive grants: the read returns the new data (memory is write-first or the reads are sequenced later). The bench checks this with a one-cycle gap for the read.

## Test plan
- Reset: assert rst mid-cycle with dbg_valid=1 → all outputs 0 immediately. After release, the first tie goes to fetch.
- Single fetch, addr=0x10, mem word 4 = 0xDEADBEEF → fetch_ready at N; fetch_rvalid=1, fetch_rdata=0xDEADBEEF, fetch_err=0 at N+1; dbg outputs stay 0.
- Both valid for 6 cycles → grants F, D, F, D, F, D; each response is routed to the matching port in the following cycle with no gaps.
- Debug write addr=0x3FC, wdata=0x12345678 → mem_en=1, mem_we=1, mem_idx=255. Next cycle dbg_rvalid=1, dbg_rdata=0. A later fetch of 0x3FC returns 0x12345678.
- Illegal accesses:
  - fetch addr=0x400 → granted, mem_en=0, next cycle fetch_err=1, fetch_rdata=0;
  - dbg write addr=0x6 → dbg_err=1 and memory unchanged.
- Valid withdrawn: dbg_valid high only in a cycle where fetch wins, then low → no debug grant and no dbg_rvalid.
